// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack, decode valid/ready
// handshake and the redirect inputs returned by decode/execute.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [1:0]  pc_src;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        misaligned;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, misaligned,
        input  imem_ack, imem_rdata, instr_ready, pc_src, imm, rs1_val
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, misaligned,
        output imem_ack, imem_rdata, instr_ready, pc_src, imm, rs1_val
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// RISC-V fetch stage: holds the PC, fetches one word per iteration and hands
// it to decode; the next PC is selected from the redirect info on accept.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_unit_if.master    bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc;
    logic [31:0] jalr_target;

    // JALR clears bit0 before the alignment check, so only bit1 can fault
    always_comb begin
        jalr_target = (bus.rs1_val + bus.imm) & ~32'h0000_0001;
        case (bus.pc_src)
            2'b01:   next_pc = pc_q + bus.imm;
            2'b10:   next_pc = jalr_target;
            default: next_pc = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // All outputs are decoded from registers only; HALT is the sticky fault
    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == ISSUE);
    assign bus.misaligned  = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with RESET_PC = 0x100.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] data);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        step();
        bus.imem_ack   = 1'b0;
    endtask

    task automatic do_accept(input logic [1:0] src, input logic [31:0] im, input logic [31:0] rs1);
        bus.instr_ready = 1'b1;
        bus.pc_src      = src;
        bus.imm         = im;
        bus.rs1_val     = rs1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (bus.instr !== 32'h13) begin n_fail++; $display("FAIL rst_instr: got %h want %h", bus.instr, 32'h13); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        n_cmp++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL rst_pc: got %h want 100", bus.pc); end
        n_cmp++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL rst_addr: got %h want 100", bus.imem_addr); end
        n_cmp++; if (bus.misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b want 0", bus.misaligned); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req: got %b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL rel_addr: got %h want 100", bus.imem_addr); end
        do_fetch(32'h0050_0093);
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 32'h0050_0093) begin n_fail++; $display("FAIL first_instr: got %h want 00500093", bus.instr); end
        n_cmp++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL first_pc: got %h want 100", bus.pc); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL first_req: got %b want 0", bus.imem_req); end
    endtask

    task automatic test_sequential();
        do_accept(2'b00, 32'h0, 32'h0);
        n_cmp++; if (bus.imem_addr !== 32'h104) begin n_fail++; $display("FAIL seq0_addr: got %h want 104", bus.imem_addr); end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL seq0_req: got %b want 1", bus.imem_req); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq0_valid: got %b want 0", bus.instr_valid); end
        do_fetch(32'h0010_0113);
        n_cmp++; if (bus.pc !== 32'h104) begin n_fail++; $display("FAIL seq1_pc: got %h want 104", bus.pc); end
        do_accept(2'b00, 32'h0, 32'h0);
        n_cmp++; if (bus.imem_addr !== 32'h108) begin n_fail++; $display("FAIL seq1_addr: got %h want 108", bus.imem_addr); end
        do_fetch(32'h0020_0193);
        do_accept(2'b01, 32'hFFFF_FEF4, 32'h0);
        n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre: got %h want fffffffc", bus.imem_addr); end
        do_fetch(32'h0030_0213);
        do_accept(2'b00, 32'h0, 32'h0);
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_branch();
        do_fetch(32'h0040_0293);
        do_accept(2'b10, 32'h0, 32'h104);
        n_cmp++; if (bus.imem_addr !== 32'h104) begin n_fail++; $display("FAIL jr_addr: got %h want 104", bus.imem_addr); end
        do_fetch(32'hFE00_0CE3);
        do_accept(2'b01, 32'hFFFF_FFF8, 32'h0);
        n_cmp++; if (bus.imem_addr !== 32'hFC) begin n_fail++; $display("FAIL br_addr: got %h want fc", bus.imem_addr); end
        do_fetch(32'h0050_0313);
        do_accept(2'b10, 32'h0, 32'h104);
        do_fetch(32'h0060_0393);
        do_accept(2'b11, 32'h1000, 32'h4000);
        n_cmp++; if (bus.imem_addr !== 32'h108) begin n_fail++; $display("FAIL src11_addr: got %h want 108", bus.imem_addr); end
    endtask

    task automatic test_stalls();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108) begin n_fail++; $display("FAIL ack_stall: req %b addr %h want 1 108", bus.imem_req, bus.imem_addr); end
            n_cmp++; if (bus.instr !== 32'h0060_0393 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL ack_stall_instr: got %h/%b want 00600393/0", bus.instr, bus.instr_valid); end
        end
        do_fetch(32'h1234_5678);
        n_cmp++; if (bus.instr !== 32'h1234_5678 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_fetch: got %h/%b want 12345678/1", bus.instr, bus.instr_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rdy_stall: valid %b req %b want 1 0", bus.instr_valid, bus.imem_req); end
            n_cmp++; if (bus.instr !== 32'h1234_5678 || bus.pc !== 32'h108) begin n_fail++; $display("FAIL rdy_stall_hold: instr %h pc %h want 12345678 108", bus.instr, bus.pc); end
        end
        do_fetch(32'hDEAD_BEEF);
        n_cmp++; if (bus.instr !== 32'h1234_5678 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL spurious_ack: got %h/%b want 12345678/1", bus.instr, bus.instr_valid); end
    endtask

    task automatic test_back_to_back();
        do_accept(2'b00, 32'h0, 32'h0);
        do_fetch(32'h0070_0413);
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h10C || bus.instr !== 32'h0070_0413) begin n_fail++; $display("FAIL b2b: valid %b pc %h instr %h want 1 10c 00700413", bus.instr_valid, bus.pc, bus.instr); end
    endtask

    task automatic test_jalr();
        do_accept(2'b10, 32'h4, 32'h2001);
        n_cmp++; if (bus.imem_addr !== 32'h2004 || bus.misaligned !== 1'b0) begin n_fail++; $display("FAIL jalr_ok: addr %h mis %b want 2004 0", bus.imem_addr, bus.misaligned); end
        do_fetch(32'h0080_0493);
        do_accept(2'b10, 32'h0, 32'h104);
        do_fetch(32'h0090_0513);
        do_accept(2'b10, 32'h2, 32'h2000);
        n_cmp++; if (bus.misaligned !== 1'b1 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_fault: mis %b valid %b want 1 0", bus.misaligned, bus.instr_valid); end
        bus.instr_ready = 1'b1;
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (bus.imem_req !== 1'b0 || bus.misaligned !== 1'b1 || bus.pc !== 32'h104) begin n_fail++; $display("FAIL halt_hold: req %b mis %b pc %h want 0 1 104", bus.imem_req, bus.misaligned, bus.pc); end
            step();
        end
        bus.instr_ready = 1'b0;
        bus.imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.misaligned !== 1'b0) begin n_fail++; $display("FAIL mid_pre: req %b addr %h mis %b want 1 100 0", bus.imem_req, bus.imem_addr, bus.misaligned); end
        rst_n = 1'b0;
        do_fetch(32'hDEAD_BEEF);
        n_cmp++; if (bus.instr !== 32'h13 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst: instr %h valid %b want 13 0", bus.instr, bus.instr_valid); end
        n_cmp++; if (bus.pc !== 32'h100 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pc: pc %h req %b want 100 0", bus.pc, bus.imem_req); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL mid_refetch: req %b addr %h want 1 100", bus.imem_req, bus.imem_addr); end
    endtask

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        bus.pc_src      = 2'b00;
        bus.imm         = 32'h0;
        bus.rs1_val     = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_stalls();
        test_back_to_back();
        test_jalr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the RISC-V core, directly upstream of the immediate sign extender and decoder. It holds the program counter and fetches one instruction word per iteration over a request/acknowledge handshake with instruction memory. It latches the word into an instruction register whose bits [31:7] drive the sign extender, and presents it to decode with a valid/ready handshake. The next PC is computed from the redirect information returned when decode/execute consumes the instruction: the sign-extended immediate and rs1.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; always equals pc
- imem_ack  in  1  memory response valid; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  instruction register; instr[31:7] feeds the sign extender
- instr_valid  out  1  instr/pc hold an unconsumed instruction
- instr_ready  in  1  consumer accepts the instruction this cycle
- pc  out  32  address of instr / current fetch address
- pc_src  in  2  next-PC select, sampled on accept: 00 pc+4, 01 pc+imm, 10 (rs1_val+imm)&~1, 11 treated as 00
- imm  in  32  sign-extended immediate from the sign extender
- rs1_val  in  32  register rs1 value for JALR
- misaligned  out  1  sticky fault: computed next PC not 4-byte aligned

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: reset state. Moves to FETCH unconditionally on the first edge with rst_n high.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack, load instr<=imem_rdata, set instr_valid<=1, go to ISSUE.
  - Without ack, stay in FETCH; addr and req are held stable.
- ISSUE: imem_req=0, instr_valid=1; instr and pc are held.
  - On instr_ready, compute next = per pc_src.
  - If next[1:0]!=0: misaligned<=1, instr_valid<=0, go to HALT; pc is unchanged.
  - Otherwise: pc<=next, instr_valid<=0, go to FETCH.
- HALT: imem_req=0, instr_valid=0, misaligned=1. Left only by reset.
- Arithmetic: all 32-bit adds are modulo 2^32 with no carry-out (0xFFFF_FFFC+4 = 0). For JALR, bit0 is cleared before the alignment check, so only bit1 can fault.
- imem_ack outside FETCH is ignored. instr_ready outside ISSUE is ignored. pc_src, imm and rs1_val are don't-care except in the accepting cycle.
- Reset values (while rst_n low, and at the first edge after it):
  - state=IDLE, pc=RESET_PC, imem_addr=RESET_PC
  - imem_req=0, instr=32'h0000_0013 (NOP), instr_valid=0, misaligned=0
- Reset mid-operation: a synchronous reset dominates all other inputs in that cycle. A coincident imem_ack or instr_ready has no effect, and any in-flight fetch is abandoned. Memory must tolerate a dropped request.

## Timing
- imem_req and instr_valid are decoded from state registers (Moore outputs); there is no combinational path from inputs to outputs.
- Reset release: IDLE in cycle 0; imem_req=1 from cycle 1.
- Fetch latency: imem_ack in cycle N gives instr_valid=1 and the new instr in cycle N+1.
- Accept latency: instr_ready in cycle M gives instr_valid=0 and imem_req=1 with the new pc in cycle M+1.
- Best-case throughput: ack in the request cycle and ready in the first valid cycle give one instruction per 2 cycles.
- instr and pc are stable for the entire time instr_valid=1.
- The misaligned flag rises in cycle M+1 after the faulting accept and stays high until reset.

## Test plan
- Reset with RESET_PC=0x100, ack next cycle with rdata 0x0050_0093 -> imem_addr=0x100, one cycle later instr_valid=1, instr=0x0050_0093, pc=0x100; during reset instr=0x13, instr_valid=0.
- Sequential and wrap: accept with pc_src=00 at pc=0x104 -> imem_addr=0x108. Accept with pc_src=00 at pc=0xFFFF_FFFC -> imem_addr=0x0.
- Branch: pc=0x104, pc_src=01, imm=0xFFFF_FFF8 -> next fetch at 0xFC. pc_src=11 -> 0x108.
- JALR: rs1_val=0x2001, imm=4 -> fetch 0x2004 (bit0 cleared from 0x2005). rs1_val=0x2000, imm=2 -> misaligned=1, HALT, imem_req stays 0 for 10 cycles, pc=0x104 unchanged.
- Stalls:
  - ack withheld 3 cycles -> imem_req/imem_addr constant, instr unchanged.
  - instr_ready held low 5 cycles -> instr_valid, instr, pc constant and no request.
  - Spurious ack in ISSUE -> instr not overwritten.
- Reset mid-operation: rst_n low in a FETCH cycle with imem_ack=1 and rdata 0xDEAD_BEEF -> instr=0x13, instr_valid=0, pc=RESET_PC. Refetch starts from RESET_PC one cycle after release.
